// File: rtl/hms_time_pkg.sv
// Shared limits and the binary-to-BCD helper for the hh:mm:ss time-of-day counter.
package hms_time_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MIN = 1;
  localparam int HR12_MAX = 12;

  // Binary 0..99 to packed {tens, ones} BCD; used for parameter presets only.
  function automatic logic [7:0] bin2bcd8(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter: wraps MAX_VAL -> MIN_VAL, clr forces MIN_VAL.
module bcd_mod_counter
  import hms_time_pkg::*;
#(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59,
  parameter int RST_VAL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] out_bcd,
  output logic       at_max
);

  localparam logic [7:0] MIN_BCD = bin2bcd8(MIN_VAL);
  localparam logic [7:0] MAX_BCD = bin2bcd8(MAX_VAL);
  localparam logic [7:0] RST_BCD = bin2bcd8(RST_VAL);

  logic [7:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = MIN_BCD;
    end else if (inc) begin
      if (val_q == MAX_BCD)
        val_d = MIN_BCD;
      else if (val_q[3:0] == 4'd9)
        val_d = {val_q[7:4] + 4'd1, 4'd0};
      else
        val_d = {val_q[7:4], val_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) val_q <= RST_BCD;
    else       val_q <= val_d;
  end

  assign out_bcd = val_q;
  assign at_max  = (val_q == MAX_BCD);

endmodule

// File: rtl/hms_time_counter.sv
// BCD hh:mm:ss time-of-day counter, 12 h or 24 h, with set mode and cascade carries.
module hms_time_counter
  import hms_time_pkg::*;
#(
  parameter bit MODE_12H = 1'b0,
  parameter int INIT_HR  = 0,
  parameter int INIT_MIN = 0,
  parameter bit INIT_PM  = 1'b0
) (
  input  logic       clk_1Hz,
  input  logic       reset,
  input  logic       run,
  input  logic       set_en,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic       pm,
  output logic       min_carry,
  output logic       hr_carry,
  output logic       day_carry
);

  localparam int HR_LO = MODE_12H ? HR12_MIN : 0;
  localparam int HR_HI = MODE_12H ? HR12_MAX : HR24_MAX;

  if (INIT_HR < HR_LO || INIT_HR > HR_HI) begin : g_bad_init_hr
    $error("hms_time_counter: INIT_HR out of range for selected hour mode");
  end
  if (INIT_MIN < 0 || INIT_MIN > MIN_MAX) begin : g_bad_init_min
    $error("hms_time_counter: INIT_MIN out of range");
  end

  logic counting;
  logic sec_max, min_max, hr_max;
  logic min_inc, hr_inc;
  logic hr_is_11;
  logic pm_q, pm_d;

  assign counting = run & ~set_en;
  assign min_inc  = set_en ? inc_min : (counting & sec_max);
  assign hr_inc   = set_en ? inc_hr  : (counting & sec_max & min_max);
  assign hr_is_11 = (hr_bcd == 8'h11);

  bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(SEC_MAX), .RST_VAL(0)) u_sec (
    .clk(clk_1Hz), .reset(reset), .clr(set_en), .inc(counting),
    .out_bcd(sec_bcd), .at_max(sec_max)
  );

  bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(MIN_MAX), .RST_VAL(INIT_MIN)) u_min (
    .clk(clk_1Hz), .reset(reset), .clr(1'b0), .inc(min_inc),
    .out_bcd(min_bcd), .at_max(min_max)
  );

  bcd_mod_counter #(.MIN_VAL(HR_LO), .MAX_VAL(HR_HI), .RST_VAL(INIT_HR)) u_hr (
    .clk(clk_1Hz), .reset(reset), .clr(1'b0), .inc(hr_inc),
    .out_bcd(hr_bcd), .at_max(hr_max)
  );

  // 12 h: meridiem flips on 11 -> 12, whether counted or set by hand.
  always_comb begin
    pm_d = pm_q;
    if (MODE_12H && hr_inc && hr_is_11) pm_d = ~pm_q;
  end

  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) pm_q <= MODE_12H ? INIT_PM : 1'b0;
    else       pm_q <= pm_d;
  end

  assign pm        = MODE_12H ? pm_q : (hr_bcd >= 8'h12);
  assign min_carry = counting & sec_max;
  assign hr_carry  = min_carry & min_max;
  assign day_carry = hr_carry & (MODE_12H ? (hr_is_11 & pm_q) : hr_max);

endmodule

// File: tb/tb_hms_time_counter.sv
// Bench for hms_time_counter: three configurations driven in parallel against a seconds-of-day model.
module tb_hms_time_counter;

  logic clk = 1'b0;
  logic reset = 1'b0, run = 1'b0, set_en = 1'b0, inc_min = 1'b0, inc_hr = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] sec_w[3], min_w[3], hr_w[3];
  logic       pm_w[3], mc_w[3], hc_w[3], dc_w[3];

  hms_time_counter #(.MODE_12H(1'b0), .INIT_HR(0), .INIT_MIN(0), .INIT_PM(1'b0)) d0 (
    .clk_1Hz(clk), .reset(reset), .run(run), .set_en(set_en), .inc_min(inc_min), .inc_hr(inc_hr),
    .sec_bcd(sec_w[0]), .min_bcd(min_w[0]), .hr_bcd(hr_w[0]), .pm(pm_w[0]),
    .min_carry(mc_w[0]), .hr_carry(hc_w[0]), .day_carry(dc_w[0]));

  hms_time_counter #(.MODE_12H(1'b0), .INIT_HR(23), .INIT_MIN(59), .INIT_PM(1'b0)) d1 (
    .clk_1Hz(clk), .reset(reset), .run(run), .set_en(set_en), .inc_min(inc_min), .inc_hr(inc_hr),
    .sec_bcd(sec_w[1]), .min_bcd(min_w[1]), .hr_bcd(hr_w[1]), .pm(pm_w[1]),
    .min_carry(mc_w[1]), .hr_carry(hc_w[1]), .day_carry(dc_w[1]));

  hms_time_counter #(.MODE_12H(1'b1), .INIT_HR(11), .INIT_MIN(59), .INIT_PM(1'b0)) d2 (
    .clk_1Hz(clk), .reset(reset), .run(run), .set_en(set_en), .inc_min(inc_min), .inc_hr(inc_hr),
    .sec_bcd(sec_w[2]), .min_bcd(min_w[2]), .hr_bcd(hr_w[2]), .pm(pm_w[2]),
    .min_carry(mc_w[2]), .hr_carry(hc_w[2]), .day_carry(dc_w[2]));

  int cfg_m12[3] = '{0, 0, 1};
  int cfg_hr[3]  = '{0, 23, 11};
  int cfg_min[3] = '{0, 59, 59};
  int cfg_pm[3]  = '{0, 0, 0};

  // Model keeps each instance as a 24 h hour plus minute/second integers.
  int mh[3], mm[3], ms[3];
  int n_chk = 0, n_fail = 0;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic void chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, idx, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mh[i] = cfg_m12[i] != 0 ? (cfg_hr[i] % 12) + (cfg_pm[i] != 0 ? 12 : 0) : cfg_hr[i];
      mm[i] = cfg_min[i];
      ms[i] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 3; i++) begin
      if (set_en) begin
        ms[i] = 0;
        if (inc_min) mm[i] = (mm[i] + 1) % 60;
        if (inc_hr)  mh[i] = (mh[i] + 1) % 24;
      end else if (run) begin
        int t;
        t = ((mh[i] * 60 + mm[i]) * 60 + ms[i] + 1) % 86400;
        mh[i] = t / 3600;
        mm[i] = (t / 60) % 60;
        ms[i] = t % 60;
      end
    end
  endfunction

  function automatic void check_all();
    for (int i = 0; i < 3; i++) begin
      bit act, top;
      int dh;
      act = run && !set_en;
      top = act && ms[i] == 59;
      dh  = cfg_m12[i] != 0 ? ((mh[i] % 12 == 0) ? 12 : mh[i] % 12) : mh[i];
      chk("sec",       i, sec_w[i], bcd(ms[i]));
      chk("min",       i, min_w[i], bcd(mm[i]));
      chk("hr",        i, hr_w[i],  bcd(dh));
      chk("pm",        i, {7'd0, pm_w[i]}, {7'd0, mh[i] >= 12});
      chk("min_carry", i, {7'd0, mc_w[i]}, {7'd0, top});
      chk("hr_carry",  i, {7'd0, hc_w[i]}, {7'd0, top && mm[i] == 59});
      chk("day_carry", i, {7'd0, dc_w[i]}, {7'd0, top && mm[i] == 59 && mh[i] == 23});
    end
  endfunction

  task automatic tick(input logic r, input logic s, input logic im, input logic ih);
    run = r; set_en = s; inc_min = im; inc_hr = ih;
    #1 check_all();
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1 check_all();
    reset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic       run, set_en, inc_min, inc_hr;
    logic [7:0] s, m, h;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 8'h00};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 8'h01};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 8'h01};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 8'h01};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h02, 8'h02};

    #1 do_reset();
    chk("rst_sec", 0, sec_w[0], 8'h00);
    chk("rst_hr",  0, hr_w[0],  8'h00);
    chk("rst_pm",  0, {7'd0, pm_w[0]}, 8'h00);

    for (int k = 0; k < 8; k++) begin
      tick(tbl[k].run, tbl[k].set_en, tbl[k].inc_min, tbl[k].inc_hr);
      chk("tbl_sec", k, sec_w[0], tbl[k].s);
      chk("tbl_min", k, min_w[0], tbl[k].m);
      chk("tbl_hr",  k, hr_w[0],  tbl[k].h);
    end

    // Async reset mid-count
    do_reset();
    repeat (37) tick(1, 0, 0, 0);
    chk("cnt37", 0, sec_w[0], 8'h37);
    do_reset();
    chk("mid_rst_sec", 0, sec_w[0], 8'h00);

    // 24 h day wrap and 12 h meridiem sequence
    repeat (59) tick(1, 0, 0, 0);
    chk("d1_sec59", 1, sec_w[1], 8'h59);
    chk("d1_day",   1, {7'd0, dc_w[1]}, 8'h01);
    chk("d2_day0",  2, {7'd0, dc_w[2]}, 8'h00);
    tick(1, 0, 0, 0);
    chk("d1_wrap_hr", 1, hr_w[1], 8'h00);
    chk("d2_hr12",    2, hr_w[2], 8'h12);
    chk("d2_pm1",     2, {7'd0, pm_w[2]}, 8'h01);
    repeat (3600) tick(1, 0, 0, 0);
    chk("d2_hr01",    2, hr_w[2], 8'h01);
    chk("d2_pm_keep", 2, {7'd0, pm_w[2]}, 8'h01);
    repeat (10) tick(0, 1, 0, 1);
    repeat (59) tick(0, 1, 1, 0);
    repeat (59) tick(1, 0, 0, 0);
    chk("d2_hr11",   2, hr_w[2], 8'h11);
    chk("d2_day_pm", 2, {7'd0, dc_w[2]}, 8'h01);
    tick(1, 0, 0, 0);
    chk("d2_mid_hr", 2, hr_w[2], 8'h12);
    chk("d2_mid_pm", 2, {7'd0, pm_w[2]}, 8'h00);

    // Set mode: seconds clear, minute wrap without hour carry, hour wrap
    do_reset();
    repeat (45) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    chk("set_sec0", 0, sec_w[0], 8'h00);
    repeat (61) tick(0, 1, 1, 0);
    chk("set_min01", 0, min_w[0], 8'h01);
    chk("set_hr00",  0, hr_w[0],  8'h00);
    repeat (25) tick(0, 1, 0, 1);
    chk("set_hr01",  0, hr_w[0],  8'h01);

    // Hold at :59 suppresses the carry until run returns
    do_reset();
    repeat (59) tick(1, 0, 0, 0);
    repeat (5) begin
      tick(0, 0, 0, 0);
      chk("hold_mc", 0, {7'd0, mc_w[0]}, 8'h00);
    end
    run = 1'b1;
    #1 chk("resume_mc", 0, {7'd0, mc_w[0]}, 8'h01);
    tick(1, 0, 0, 0);
    chk("resume_min", 0, min_w[0], 8'h01);
    chk("resume_sec", 0, sec_w[0], 8'h00);

    // Both increments together, then increments ignored outside set mode
    do_reset();
    repeat (5)  tick(0, 1, 0, 1);
    repeat (59) tick(0, 1, 1, 0);
    tick(0, 1, 1, 1);
    chk("both_hr",  0, hr_w[0],  8'h06);
    chk("both_min", 0, min_w[0], 8'h00);
    tick(0, 0, 1, 1);
    chk("ign_min", 0, min_w[0], 8'h00);

    // Randomized run/set/increment traffic with occasional resets
    begin
      bit setph;
      setph = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 299) == 0) do_reset();
        if ($urandom_range(0, 39) == 0) setph = ~setph;
        tick($urandom_range(0, 5) != 0, setph, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
